// File: rtl/qsic_dma_pkg.sv
// qsic_dma_pkg: shared state encoding and default sizing for the QBUS DMA arbiter.
package qsic_dma_pkg;

   // State encodings, kept as named constants so other blocks can decode them.
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_XFER  = 3'd1;
   localparam logic [2:0] ST_GAP   = 3'd2;
   localparam logic [2:0] ST_YIELD = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      XFER  = ST_XFER,
      GAP   = ST_GAP,
      YIELD = ST_YIELD,
      DONE  = ST_DONE
   } dma_state_e;

   // One QBUS word is two bytes; the byte address advances by this much per word.
   localparam int WORD_BYTES = 2;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_AW    = 22;
   localparam int DEF_WCW   = 16;
   localparam int DEF_BURST = 8;

endpackage

// File: rtl/dma_arbiter_rr_pick.sv
// rr_pick: combinational round-robin finder. Searches req from ptr+1 upward,
// wrapping, skipping masked entries; returns one-hot winner, its index and a found flag.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [NREQ-1:0] mask_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [NREQ-1:0] onehot_o,
   output logic [IW-1:0]   idx_o,
   output logic            found_o
);

   int          cand_s;
   logic [IW-1:0] cand_idx_s;

   // Walk the rotated request vector and keep the first eligible requester.
   always_comb begin
      onehot_o   = {NREQ{1'b0}};
      idx_o      = {IW{1'b0}};
      found_o    = 1'b0;
      cand_s     = 0;
      cand_idx_s = {IW{1'b0}};
      for (int i = 1; i <= NREQ; i++) begin
         cand_s     = (int'(ptr_i) + i) % NREQ;
         cand_idx_s = IW'(cand_s);
         if (!found_o && req_i[cand_idx_s] && !mask_i[cand_idx_s]) begin
            found_o              = 1'b1;
            idx_o                = cand_idx_s;
            onehot_o[cand_idx_s] = 1'b1;
         end else begin
            found_o = found_o;
         end
      end
   end

endmodule

// File: rtl/dma_arbiter.sv
// dma_arbiter: shares the single QBUS bus-master engine among NREQ DMA requesters.
// Round-robin grant, one master word cycle at a time, address/count sequencing and
// completion/NXM reporting. Optional per-grant burst limit with resume tables is
// enabled by defining DMA_BURST_LIMIT_EN.
module dma_arbiter
   import qsic_dma_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int AW    = DEF_AW,
   parameter int WCW   = DEF_WCW,
   parameter int BURST = DEF_BURST
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ-1:0]     req_write,
   input  logic [NREQ*AW-1:0]  req_addr,
   input  logic [NREQ*WCW-1:0] req_count,
   output logic [NREQ-1:0]     grant,
   output logic [NREQ-1:0]     word_strobe,
   output logic [NREQ-1:0]     done,
   output logic [NREQ-1:0]     err,
   output logic [AW-1:0]       cur_addr,
   output logic                dma_read,
   output logic                dma_write,
   input  logic                mst_done,
   input  logic                mst_nxm
);

   localparam int IW = $clog2(NREQ);

   // Configurations outside the supported range stop elaboration.
   if (NREQ < 2 || NREQ > 8 || BURST < 1) begin : g_cfg_check
      $error("dma_arbiter: unsupported NREQ or BURST");
   end

   dma_state_e      state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [WCW-1:0]  count_q, count_d;
   logic            write_q, write_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [NREQ-1:0] word_strobe_q, word_strobe_d;
   logic [NREQ-1:0] done_q, done_d;
   logic [NREQ-1:0] err_q, err_d;
   logic [NREQ-1:0] mask_q, mask_d;
   logic            dma_read_q, dma_read_d;
   logic            dma_write_q, dma_write_d;

   logic [NREQ-1:0] pick_onehot_s;
   logic [IW-1:0]   pick_idx_s;
   logic            pick_found_s;
   logic [NREQ-1:0] owner_oh_s;
   logic [AW-1:0]   sel_addr_s;
   logic [WCW-1:0]  sel_count_s;
   logic [AW-1:0]   port_addr_s  [NREQ];
   logic [WCW-1:0]  port_count_s [NREQ];

`ifdef DMA_BURST_LIMIT_EN
   localparam int BW = $clog2(BURST + 1);
   logic [BW-1:0]   burst_q, burst_d;
   logic [AW-1:0]   addr_tab_q [NREQ];
   logic [AW-1:0]   addr_tab_d [NREQ];
   logic [WCW-1:0]  cnt_tab_q  [NREQ];
   logic [WCW-1:0]  cnt_tab_d  [NREQ];
   logic [NREQ-1:0] resume_q, resume_d;
`endif

   for (genvar g = 0; g < NREQ; g++) begin : g_port
      assign port_addr_s[g]  = req_addr[g*AW +: AW];
      assign port_count_s[g] = req_count[g*WCW +: WCW];
   end

   assign owner_oh_s = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_pick (
      .req_i    (req),
      .mask_i   (mask_q),
      .ptr_i    (ptr_q),
      .onehot_o (pick_onehot_s),
      .idx_o    (pick_idx_s),
      .found_o  (pick_found_s)
   );

   // Next-state and registered-output computation for the grant/transfer sequencer.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      owner_d       = owner_q;
      addr_d        = addr_q;
      count_d       = count_q;
      write_d       = write_q;
      grant_d       = grant_q;
      word_strobe_d = {NREQ{1'b0}};
      done_d        = {NREQ{1'b0}};
      err_d         = {NREQ{1'b0}};
      mask_d        = {NREQ{1'b0}};
      dma_read_d    = dma_read_q;
      dma_write_d   = dma_write_q;
      sel_addr_s    = port_addr_s[pick_idx_s];
      sel_count_s   = port_count_s[pick_idx_s];
`ifdef DMA_BURST_LIMIT_EN
      burst_d       = burst_q;
      addr_tab_d    = addr_tab_q;
      cnt_tab_d     = cnt_tab_q;
      resume_d      = resume_q;
      // A requester that yielded earlier continues from its saved position.
      if (resume_q[pick_idx_s]) begin
         sel_addr_s  = addr_tab_q[pick_idx_s];
         sel_count_s = cnt_tab_q[pick_idx_s];
      end else begin
         sel_addr_s  = port_addr_s[pick_idx_s];
         sel_count_s = port_count_s[pick_idx_s];
      end
`endif

      case (state_q)
         IDLE: begin
            if (pick_found_s) begin
               owner_d = pick_idx_s;
               ptr_d   = pick_idx_s;
               grant_d = pick_onehot_s;
               write_d = req_write[pick_idx_s];
               addr_d  = sel_addr_s;
               count_d = sel_count_s;
`ifdef DMA_BURST_LIMIT_EN
               burst_d = {BW{1'b0}};
`endif
               if (sel_count_s == {WCW{1'b0}}) begin
                  // Zero-length block: pass through GAP (no bus cycle) so the
                  // requester sees its grant for a cycle before done.
                  state_d     = GAP;
                  dma_read_d  = 1'b0;
                  dma_write_d = 1'b0;
               end else begin
                  state_d     = XFER;
                  dma_write_d = req_write[pick_idx_s];
                  dma_read_d  = !req_write[pick_idx_s];
               end
            end else begin
               state_d = IDLE;
            end
         end

         XFER: begin
            if (mst_done) begin
               word_strobe_d = owner_oh_s;
               dma_read_d    = 1'b0;
               dma_write_d   = 1'b0;
               if (mst_nxm) begin
                  // Timed-out cycle ends the block; address and count stay put.
                  state_d = DONE;
                  done_d  = owner_oh_s;
                  err_d   = owner_oh_s;
               end else begin
                  addr_d  = addr_q + AW'(WORD_BYTES);
                  count_d = count_q - {{(WCW-1){1'b0}}, 1'b1};
`ifdef DMA_BURST_LIMIT_EN
                  burst_d = burst_q + {{(BW-1){1'b0}}, 1'b1};
                  if (count_q == {{(WCW-1){1'b0}}, 1'b1}) begin
                     state_d = DONE;
                     done_d  = owner_oh_s;
                  end else if (burst_q == BW'(BURST - 1)) begin
                     state_d = YIELD;
                  end else begin
                     state_d = GAP;
                  end
`else
                  if (count_q == {{(WCW-1){1'b0}}, 1'b1}) begin
                     state_d = DONE;
                     done_d  = owner_oh_s;
                  end else begin
                     state_d = GAP;
                  end
`endif
               end
            end else begin
               state_d = XFER;
            end
         end

         GAP: begin
            if (count_q == {WCW{1'b0}}) begin
               state_d = DONE;
               done_d  = owner_oh_s;
            end else begin
               state_d     = XFER;
               dma_write_d = write_q;
               dma_read_d  = !write_q;
            end
         end

`ifdef DMA_BURST_LIMIT_EN
         YIELD: begin
            addr_tab_d[owner_q] = addr_q;
            cnt_tab_d[owner_q]  = count_q;
            resume_d[owner_q]   = 1'b1;
            grant_d             = {NREQ{1'b0}};
            state_d             = IDLE;
         end
`endif

         DONE: begin
            grant_d = {NREQ{1'b0}};
            mask_d  = owner_oh_s;
`ifdef DMA_BURST_LIMIT_EN
            resume_d[owner_q] = 1'b0;
`endif
            state_d = IDLE;
         end

         default: begin
            state_d     = IDLE;
            grant_d     = {NREQ{1'b0}};
            dma_read_d  = 1'b0;
            dma_write_d = 1'b0;
         end
      endcase
   end

   // Sequencer state and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         ptr_q         <= IW'(NREQ - 1);
         owner_q       <= {IW{1'b0}};
         addr_q        <= {AW{1'b0}};
         count_q       <= {WCW{1'b0}};
         write_q       <= 1'b0;
         grant_q       <= {NREQ{1'b0}};
         word_strobe_q <= {NREQ{1'b0}};
         done_q        <= {NREQ{1'b0}};
         err_q         <= {NREQ{1'b0}};
         mask_q        <= {NREQ{1'b0}};
         dma_read_q    <= 1'b0;
         dma_write_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         owner_q       <= owner_d;
         addr_q        <= addr_d;
         count_q       <= count_d;
         write_q       <= write_d;
         grant_q       <= grant_d;
         word_strobe_q <= word_strobe_d;
         done_q        <= done_d;
         err_q         <= err_d;
         mask_q        <= mask_d;
         dma_read_q    <= dma_read_d;
         dma_write_q   <= dma_write_d;
      end
   end

`ifdef DMA_BURST_LIMIT_EN
   // Resume tables and per-grant word counter.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         burst_q  <= {BW{1'b0}};
         resume_q <= {NREQ{1'b0}};
         for (int i = 0; i < NREQ; i++) begin
            addr_tab_q[i] <= {AW{1'b0}};
            cnt_tab_q[i]  <= {WCW{1'b0}};
         end
      end else begin
         burst_q    <= burst_d;
         resume_q   <= resume_d;
         addr_tab_q <= addr_tab_d;
         cnt_tab_q  <= cnt_tab_d;
      end
   end
`endif

   assign grant       = grant_q;
   assign word_strobe = word_strobe_q;
   assign done        = done_q;
   assign err         = err_q;
   assign cur_addr    = addr_q;
   assign dma_read    = dma_read_q;
   assign dma_write   = dma_write_q;

endmodule
